score_ssd_display: RTL and testbench

//   Downstream consumer of the game's 16-bit score. Converts score to BCD with a

---
 rtl/score_ssd_display_pkg.sv | 51 +++++
 rtl/score_ssd_display_if.sv | 10 +
 rtl/score_ssd_display_bin2bcd_seq.sv | 67 ++++++
 rtl/score_ssd_display.sv | 93 +++++++++
 tb/tb_score_ssd_display.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/score_ssd_display_pkg.sv
// Shared definitions for the score display: segment codes, converter states,
// and the double-dabble digit adjust step.
package score_ssd_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [15:0] MAX_SHOWN = 16'd9999;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Pre-shift correction: any nibble >= 5 would overflow past 9 after doubling.
    function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
        logic [19:0] res;
        res = bcd;
        for (int k = 0; k < 5; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_ssd_display_if.sv
// Score input and seven-segment outputs between the score producer and the display block.
interface score_ssd_display_if;
    logic [15:0] score;
    logic [3:0]  an;
    logic [6:0]  ssd;
    logic        dp;

    modport master (output score, input an, ssd, dp);
    modport slave  (input score, output an, ssd, dp);
endinterface

// File: rtl/score_ssd_display_bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter, one double-dabble step per cycle.
module score_ssd_display_bin2bcd_seq
    import score_ssd_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    bcd_state_e  r_state;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_iter;
    logic        r_busy;
    logic        r_done;
    logic [19:0] w_adj;

    assign w_adj = dd_adjust(r_bcd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bin   <= bin;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top adjusted bit cannot be set for a 16-bit input, so it is dropped.
                    {r_bcd, r_bin} <= {w_adj[18:0], r_bin, 1'b0};
                    r_iter         <= r_iter + 4'd1;
                    if (r_iter == 4'd15) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/score_ssd_display.sv
// Score to BCD conversion, tear-free digit latch and 4-digit common-anode scan driver.
module score_ssd_display
    import score_ssd_display_pkg::*;
#(
    parameter int unsigned REFRESH_BITS  = 18,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    score_ssd_display_if.slave   disp
);

    localparam logic [REFRESH_BITS-1:0] SCAN_ONE = 1;

    logic [15:0]             r_last_score;
    logic [15:0]             r_digits;
    logic                    r_ovf;
    logic [REFRESH_BITS-1:0] r_scan;
    logic [3:0]              r_an;
    logic [6:0]              r_ssd;
    logic                    r_dp;

    logic        w_start;
    logic        w_busy;
    logic        w_done;
    logic [19:0] w_bcd;
    logic [1:0]  w_sel;
    logic [3:0]  w_dig [4];
    logic [3:0]  w_zero_up;
    logic        w_blank;
    logic [6:0]  w_seg;

    assign w_start = (disp.score != r_last_score) && !w_busy;

    score_ssd_display_bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .bin   (disp.score),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    assign w_sel = r_scan[REFRESH_BITS-1 -: 2];

    // w_zero_up[k]: digit k and every digit above it are zero.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_dig[k] = r_digits[4*k +: 4];
        end
        w_zero_up[3] = (w_dig[3] == 4'd0);
        for (int k = 2; k >= 0; k--) begin
            w_zero_up[k] = (w_dig[k] == 4'd0) && w_zero_up[k+1];
        end
        w_blank = BLANK_LEADING && !r_ovf && (w_sel != 2'd0) && w_zero_up[w_sel];
        w_seg   = w_blank ? SEG_BLANK : seg_encode(w_dig[w_sel]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_score <= 16'hFFFF;
            r_digits     <= '0;
            r_ovf        <= 1'b0;
            r_scan       <= '0;
            r_an         <= 4'b1111;
            r_ssd        <= SEG_BLANK;
            r_dp         <= 1'b1;
        end else begin
            if (w_start) begin
                r_last_score <= disp.score;
            end
            if (w_done) begin
                if (w_bcd[19:16] != 4'd0) begin
                    r_digits <= 16'h9999;
                    r_ovf    <= 1'b1;
                end else begin
                    r_digits <= w_bcd[15:0];
                    r_ovf    <= 1'b0;
                end
            end
            r_scan <= r_scan + SCAN_ONE;
            r_an   <= ~(4'b0001 << w_sel);
            r_ssd  <= w_seg;
            r_dp   <= ~(r_ovf && (w_sel == 2'd0));
        end
    end

    assign disp.an  = r_an;
    assign disp.ssd = r_ssd;
    assign disp.dp  = r_dp;

endmodule

// File: tb/tb_score_ssd_display.sv
// Directed bench for score_ssd_display with a short scan counter; two instances cover
// both leading-zero modes.
module tb_score_ssd_display;

    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    score_ssd_display_if bus ();
    score_ssd_display_if bus_nb ();

    score_ssd_display #(.REFRESH_BITS(4), .BLANK_LEADING(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (bus.slave)
    );

    score_ssd_display #(.REFRESH_BITS(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .disp  (bus_nb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_score(input logic [15:0] s);
        bus.score    = s;
        bus_nb.score = s;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"}, {28'd0, bus.an}, 32'hF);
        chk({tag, "_ssd"}, {25'd0, bus.ssd}, 32'h7F);
        chk({tag, "_dp"}, {31'd0, bus.dp}, 32'd1);
        chk({tag, "_digits"}, {16'd0, dut.r_digits}, 32'd0);
    endtask

    // One full scan (4 digits x 4 cycles); scan counter value is cyc-1 after each tick.
    task automatic check_scan(input string tag, input bit nb, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input bit ovf);
        logic [6:0] codes [4];
        logic [3:0] exp_an;
        logic [1:0] sel;
        logic [3:0] got_an;
        logic [6:0] got_ssd;
        logic       got_dp;
        codes[0] = s0;
        codes[1] = s1;
        codes[2] = s2;
        codes[3] = s3;
        for (int i = 0; i < 16; i++) begin
            tick();
            sel    = 2'((cyc - 1) >> 2);
            exp_an = ~(4'b0001 << sel);
            got_an  = nb ? bus_nb.an  : bus.an;
            got_ssd = nb ? bus_nb.ssd : bus.ssd;
            got_dp  = nb ? bus_nb.dp  : bus.dp;
            chk({tag, "_an"}, {28'd0, got_an}, {28'd0, exp_an});
            chk({tag, "_ssd"}, {25'd0, got_ssd}, {25'd0, codes[sel]});
            chk({tag, "_dp"}, {31'd0, got_dp}, (ovf && sel == 2'd0) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        bit torn;
        set_score(16'd0);
        reset = 1'b1;
        tick();
        tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        cyc   = 0;

        // Score 0: only the rightmost digit lit.
        repeat (18) tick();
        chk("zero_digits", {16'd0, dut.r_digits}, 32'h0000);
        check_scan("zero", 1'b0, 7'b0000001, BL, BL, BL, 1'b0);

        // 1234: exact 18-cycle latency.
        set_score(16'd1234);
        repeat (17) tick();
        chk("lat17_digits", {16'd0, dut.r_digits}, 32'h0000);
        tick();
        chk("lat18_digits", {16'd0, dut.r_digits}, 32'h1234);
        check_scan("d1234", 1'b0, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 1'b0);

        // 12345 overflows to 9999 with dp on the rightmost digit.
        set_score(16'd12345);
        repeat (18) tick();
        chk("ovf_digits", {16'd0, dut.r_digits}, 32'h9999);
        chk("ovf_flag", {31'd0, dut.r_ovf}, 32'd1);
        check_scan("ovf", 1'b0, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100, 1'b1);

        // 42, then 57 mid-conversion: 42 lands first, 57 follows, nothing mixed.
        set_score(16'd42);
        torn = 1'b0;
        for (int t = 1; t <= 36; t++) begin
            tick();
            if (t == 5) set_score(16'd57);
            if (!(dut.r_digits inside {16'h9999, 16'h0042, 16'h0057})) torn = 1'b1;
            if (t == 17) chk("p42_t17", {16'd0, dut.r_digits}, 32'h9999);
            if (t == 18) chk("p42_t18", {16'd0, dut.r_digits}, 32'h0042);
            if (t == 35) chk("p57_t35", {16'd0, dut.r_digits}, 32'h0042);
        end
        chk("p57_t36", {16'd0, dut.r_digits}, 32'h0057);
        chk("no_torn", {31'd0, torn}, 32'd0);
        check_scan("d57", 1'b0, 7'b0001111, 7'b0100100, BL, BL, 1'b0);

        // Reset during SHIFT iteration 8, then reconversion of 808.
        set_score(16'd808);
        tick();
        repeat (8) tick();
        reset = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        reset = 1'b0;
        cyc   = 0;
        repeat (17) tick();
        chk("rec_t17", {16'd0, dut.r_digits}, 32'h0000);
        tick();
        chk("rec_t18", {16'd0, dut.r_digits}, 32'h0808);
        check_scan("d808", 1'b0, 7'b0000000, 7'b0000001, 7'b0000000, BL, 1'b0);

        // Score 7: leading zeros shown on one instance, blanked on the other.
        set_score(16'd7);
        repeat (18) tick();
        check_scan("nb7", 1'b1, 7'b0001111, 7'b0000001, 7'b0000001, 7'b0000001, 1'b0);
        check_scan("bl7", 1'b0, 7'b0001111, BL, BL, BL, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
